// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Exact sum of two WIDTH-bit operands never loses its carry.
  function automatic int sum_w(input int width);
    return width + 1;
  endfunction

  // Worst case err_sum is (2**(WIDTH+1)-1) * 2**SAMPLES_LOG2, so this cannot overflow.
  function automatic int acc_w(input int width, input int samples_log2);
    return width + 1 + samples_log2;
  endfunction

  // Must be able to hold the full window count 2**SAMPLES_LOG2.
  function automatic int cnt_w(input int samples_log2);
    return samples_log2 + 1;
  endfunction

endpackage

// File: rtl/approx_err_absdiff.sv
// Combinational magnitude of the difference of two unsigned values.
module approx_err_absdiff #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  // Subtract the smaller from the larger so either ordering gives a positive magnitude.
  always_comb begin
    diff = {W{1'b0}};
    if (a >= b) begin
      diff = a - b;
    end else begin
      diff = b - a;
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error monitor: compares approximate sums against the exact sum and
// reports sum of absolute errors, MAE, max error and error count per window.
module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SAMPLES_LOG2 = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [WIDTH:0]               in_approx,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH+SAMPLES_LOG2:0]  err_sum,
  output logic [WIDTH:0]               mae,
  output logic [WIDTH:0]               max_err,
  output logic [SAMPLES_LOG2:0]        err_count
);

  localparam int SUM_W = sum_w(WIDTH);
  localparam int ACC_W = acc_w(WIDTH, SAMPLES_LOG2);
  localparam int CNT_W = cnt_w(SAMPLES_LOG2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((2 ** SAMPLES_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_r;
  logic [CNT_W-1:0]   sample_cnt_r;
  logic               ready_r;
  logic               busy_r;
  logic               done_r;
  logic [ACC_W-1:0]   err_sum_r;
  logic [SUM_W-1:0]   mae_r;
  logic [SUM_W-1:0]   max_err_r;
  logic [CNT_W-1:0]   err_count_r;

  logic               s1_valid_r;
  logic [SUM_W-1:0]   s1_exact_r;
  logic [SUM_W-1:0]   s1_approx_r;
  logic [SUM_W-1:0]   diff_s;

  logic [ACC_W-1:0]   acc_sum_r;
  logic [SUM_W-1:0]   acc_max_r;
  logic [CNT_W-1:0]   acc_cnt_r;

  logic               accept_s;
  logic               open_window_s;

  assign accept_s      = in_valid & ready_r & (state_r == RUN);
  assign open_window_s = (state_r == IDLE) & start;

  assign in_ready  = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err_sum   = err_sum_r;
  assign mae       = mae_r;
  assign max_err   = max_err_r;
  assign err_count = err_count_r;

  // Window control FSM; result outputs only change when leaving DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      sample_cnt_r <= {CNT_W{1'b0}};
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_sum_r    <= {ACC_W{1'b0}};
      mae_r        <= {SUM_W{1'b0}};
      max_err_r    <= {SUM_W{1'b0}};
      err_count_r  <= {CNT_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= RUN;
            sample_cnt_r <= {CNT_W{1'b0}};
            ready_r      <= 1'b1;
            busy_r       <= 1'b1;
          end
        end
        RUN: begin
          if (accept_s) begin
            sample_cnt_r <= sample_cnt_r + CNT_ONE;
            // Drop ready on the very edge that takes the last sample.
            if (sample_cnt_r == LAST_IDX) begin
              state_r <= DRAIN;
              ready_r <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid_r) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
          end
        end
        DONE: begin
          err_sum_r   <= acc_sum_r;
          mae_r       <= SUM_W'(acc_sum_r >> SAMPLES_LOG2);
          max_err_r   <= acc_max_r;
          err_count_r <= acc_cnt_r;
          done_r      <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture exact and approximate sums of each accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_exact_r  <= {SUM_W{1'b0}};
      s1_approx_r <= {SUM_W{1'b0}};
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_exact_r  <= {1'b0, in_a} + {1'b0, in_b};
        s1_approx_r <= in_approx;
      end
    end
  end

  approx_err_absdiff #(
    .W (SUM_W)
  ) u_absdiff (
    .a    (s1_exact_r),
    .b    (s1_approx_r),
    .diff (diff_s)
  );

  // Stage 2: fold each error magnitude into the window accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_r <= {ACC_W{1'b0}};
      acc_max_r <= {SUM_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
    end else if (open_window_s) begin
      acc_sum_r <= {ACC_W{1'b0}};
      acc_max_r <= {SUM_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
    end else if (s1_valid_r) begin
      acc_sum_r <= acc_sum_r + ACC_W'(diff_s);
      if (diff_s > acc_max_r) begin
        acc_max_r <= diff_s;
      end
      if (diff_s != {SUM_W{1'b0}}) begin
        acc_cnt_r <= acc_cnt_r + CNT_ONE;
      end
    end
  end

endmodule
